// File: rtl/aes_pkg.sv
// Shared AES types, the forward S-box table and the ShiftRows index helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [7:0] byte_t;
  // Element 0 sits in the MSBs, so byte k of the state is at [127-8k -: 8].
  typedef byte_t [0:15] state_t;

  localparam byte_t SBOX_ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Destination byte index of source byte k after ShiftRows. Row r of column c
  // moves left by r columns, so it lands in column (c - r) mod 4, same row.
  function automatic logic [3:0] shift_rows_idx(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] col;
    row = k[1:0];
    col = k[3:2];
    return {2'(col - row), row};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational forward AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = SBOX_ROM[din];

endmodule

// File: rtl/sub_shift_stage.sv
// Iterative AES SubBytes + ShiftRows stage with valid/ready on both sides.
// LANES bytes are substituted per cycle and written straight into their
// ShiftRows position, so the finished register needs no further permutation.
module sub_shift_stage
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   valid_i,
  input  logic [AES_BLOCK_W-1:0] block_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [AES_BLOCK_W-1:0] block_o,
  input  logic                   ready_i
);

  localparam int ITERS = 16 / LANES;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           src_q;
  state_t           dst_q;
  logic             valid_q;

  logic [3:0] lane_idx [LANES];
  byte_t      sbox_in  [LANES];
  byte_t      sbox_out [LANES];

  // Pick the source bytes handled by each lane in the current iteration.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(32'(cnt_q) * LANES + l);
      sbox_in[l]  = src_q[lane_idx[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sbox_in[g]),
      .dout (sbox_out[g])
    );
  end

  assign ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
  assign valid_o = valid_q;
  assign block_o = dst_q;

  // Handshake FSM, iteration counter and the source/result registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            src_q   <= block_i;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            dst_q[shift_rows_idx(lane_idx[l])] <= sbox_out[l];
          end
          if (cnt_q == CNT_LAST) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (valid_i) begin
              src_q   <= block_i;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Bench for sub_shift_stage: transaction-level reference with a GF(2^8) S-box.
module tb_sub_shift_stage;

  localparam int LANES = 4;
  localparam int ITERS = 16 / LANES;

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid_i = 1'b0;
  logic [127:0] block_i = '0;
  logic         ready_i = 1'b0;
  logic         ready_o;
  logic         valid_o;
  logic [127:0] block_o;

  always #5 clk = ~clk;

  sub_shift_stage #(.LANES(LANES)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .valid_i   (valid_i),
    .block_i   (block_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .block_o   (block_o),
    .ready_i   (ready_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: a block in flight with its remaining compute cycles,
  // and the result presented downstream.
  bit           m_busy  = 1'b0;
  bit           m_have  = 1'b0;
  bit           m_clean = 1'b1;
  int           m_left  = 0;
  logic [127:0] m_res   = '0;
  logic [127:0] m_out   = '0;
  logic [7:0]   ref_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift_ref(input logic [127:0] din);
    logic [127:0] res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = ref_tab[din[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    return res;
  endfunction

  function automatic bit model_ready();
    return !m_busy && (!m_have || ready_i);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: advance the reference at the edge, compare on the falling edge.
  task automatic tick();
    bit acc;
    bit cons;
    @(posedge clk);
    acc  = valid_i && model_ready();
    cons = m_have && ready_i;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_have  = 1'b0;
      m_clean = 1'b1;
      m_out   = '0;
    end else begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_have = 1'b1;
          m_out  = m_res;
        end
      end else if (cons) begin
        m_have = 1'b0;
      end
      if (acc) begin
        m_busy  = 1'b1;
        m_clean = 1'b0;
        m_left  = ITERS;
        m_res   = sub_shift_ref(block_i);
      end
    end
    @(negedge clk);
    chk("ready_o", 128'(ready_o), 128'(model_ready()));
    chk("valid_o", 128'(valid_o), 128'(m_have));
    if (m_have || m_clean) chk("block_o", block_o, m_out);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 64) begin
      tick();
      n++;
    end
    if (!valid_o) chk("wait_valid_timeout", 128'(valid_o), 128'(1));
  endtask

  initial begin
    int n;
    int outs;
    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_ref(8'(i));

    // Reset and idle state
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_valid", 128'(valid_o), 128'(0));
    chk("reset_block", block_o, 128'(0));
    chk("reset_ready", 128'(ready_o), 128'(1));

    // Pin the reference itself
    chk("ref_sbox_00", 128'(sbox_ref(8'h00)), 128'(8'h63));
    chk("ref_sbox_53", 128'(sbox_ref(8'h53)), 128'(8'hed));
    chk("ref_fips", sub_shift_ref(FIPS_IN), FIPS_OUT);

    // Zero vector with latency measurement
    valid_i = 1'b1;
    block_i = '0;
    ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    block_i = FIPS_IN;
    wait_valid(n);
    chk("zero_latency", 128'(n), 128'(ITERS));
    chk("zero_block", block_o, ZERO_OUT);

    // Backpressure: output held, stage not ready
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'(i % 2);
      tick();
      chk("bp_block", block_o, ZERO_OUT);
      chk("bp_ready", 128'(ready_o), 128'(0));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("consume_valid", 128'(valid_o), 128'(0));

    // FIPS-197 round 1 vector
    ready_i = 1'b0;
    valid_i = 1'b1;
    block_i = FIPS_IN;
    tick();
    valid_i = 1'b0;
    block_i = '1;
    wait_valid(n);
    chk("fips_block", block_o, FIPS_OUT);
    ready_i = 1'b1;
    tick();

    // Back-to-back with both sides always willing
    outs = 0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 6 * (ITERS + 1); i++) begin
      block_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (valid_o) outs++;
    end
    chk("b2b_count", 128'(outs), 128'(6));
    valid_i = 1'b0;
    repeat (ITERS + 3) tick();

    // Reset while a block is being computed
    ready_i = 1'b0;
    valid_i = 1'b1;
    block_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_flight_valid", 128'(valid_o), 128'(0));
    chk("rst_flight_block", block_o, 128'(0));
    chk("rst_flight_ready", 128'(ready_o), 128'(1));
    repeat (ITERS + 2) tick();
    chk("rst_flight_no_output", 128'(valid_o), 128'(0));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      valid_i = ($urandom_range(0, 99) < 60);
      ready_i = ($urandom_range(0, 99) < 70);
      block_i = {$urandom, $urandom, $urandom, $urandom};
      reset_n = ($urandom_range(0, 249) != 0);
      tick();
    end
    reset_n = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (ITERS + 3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
